// File: rtl/cpu_defs.sv
// Shared definitions for the pipeline control unit: stall bit positions,
// canonical stall vectors and the multi-cycle sequencer state encoding.
package cpu_defs;

    localparam int unsigned STALL_PC  = 0;
    localparam int unsigned STALL_IF  = 1;
    localparam int unsigned STALL_ID  = 2;
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IDR  = 6'b000111;
    localparam logic [5:0] STALL_EXR  = 6'b001111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mc_counter.sv
// Down-counter for multi-cycle EX operations: load, decrement, zero detect,
// synchronous clear and asynchronous active-low reset.
module mc_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges ID/EX stall requests into a per-stage stall vector,
// sequences multi-cycle EX ops, handles exception flush and counts stall cycles.
module pipe_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_stallreq,
    input  logic              ex_mc_start,
    input  logic [CNT_W-1:0]  ex_mc_cycles,
    input  logic              flush_req,
    input  logic [PC_W-1:0]   exc_pc,
    output logic [5:0]        stall,
    output logic              mc_busy,
    output logic              mc_done,
    output logic              mc_cancel,
    output logic              o_flush,
    output logic [PC_W-1:0]   o_new_pc,
    output logic [PERF_W-1:0] o_stall_cnt
);

    logic [1:0] state, state_next;
    logic       mc_start;
    logic       cnt_zero;

    // An op presented while a flush is pending or being applied belongs to a
    // squashed instruction and must not start.
    assign mc_start = (state == ST_IDLE) && ex_mc_start && (ex_mc_cycles != '0)
                      && !flush_req && !o_flush;

    mc_counter #(
        .CNT_W(CNT_W)
    ) u_mc_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush_req),
        .load    (mc_start),
        .load_val(ex_mc_cycles - CNT_W'(1)),
        .dec     (state == ST_BUSY),
        .zero    (cnt_zero)
    );

    always_comb begin
        state_next = state;
        if (flush_req) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (mc_start) state_next = ST_BUSY;
                ST_BUSY: if (cnt_zero) state_next = ST_DONE;
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        stall = STALL_NONE;
        if (!rst || flush_req || o_flush) begin
            stall = STALL_NONE;
        end else if (mc_start || state == ST_BUSY) begin
            stall = STALL_EXR;
        end else if (id_stallreq) begin
            stall = STALL_IDR;
        end
    end

    assign mc_busy = (state == ST_BUSY);
    assign mc_done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_flush   <= 1'b0;
            o_new_pc  <= '0;
            mc_cancel <= 1'b0;
        end else begin
            o_flush   <= flush_req;
            o_new_pc  <= flush_req ? exc_pc : '0;
            mc_cancel <= flush_req && (state != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_stall_cnt <= '0;
        end else if (stall[STALL_PC] && o_stall_cnt != '1) begin
            o_stall_cnt <= o_stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each task queues the per-cycle expected outputs
// and compares them against the DUT at the falling edge.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        id_stallreq;
    logic        ex_mc_start;
    logic [5:0]  ex_mc_cycles;
    logic        flush_req;
    logic [31:0] exc_pc;

    logic [5:0]  stall, stall4;
    logic        mc_busy, mc_done, mc_cancel, o_flush;
    logic        mc_busy4, mc_done4, mc_cancel4, o_flush4;
    logic [31:0] o_new_pc, o_new_pc4;
    logic [31:0] o_stall_cnt;
    logic [3:0]  o_stall_cnt4;

    pipe_ctrl #(.CNT_W(6), .PC_W(32), .PERF_W(32)) dut (
        .clk(clk), .rst(rst), .id_stallreq(id_stallreq), .ex_mc_start(ex_mc_start),
        .ex_mc_cycles(ex_mc_cycles), .flush_req(flush_req), .exc_pc(exc_pc),
        .stall(stall), .mc_busy(mc_busy), .mc_done(mc_done), .mc_cancel(mc_cancel),
        .o_flush(o_flush), .o_new_pc(o_new_pc), .o_stall_cnt(o_stall_cnt)
    );

    pipe_ctrl #(.CNT_W(6), .PC_W(32), .PERF_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_stallreq(id_stallreq), .ex_mc_start(ex_mc_start),
        .ex_mc_cycles(ex_mc_cycles), .flush_req(flush_req), .exc_pc(exc_pc),
        .stall(stall4), .mc_busy(mc_busy4), .mc_done(mc_done4), .mc_cancel(mc_cancel4),
        .o_flush(o_flush4), .o_new_pc(o_new_pc4), .o_stall_cnt(o_stall_cnt4)
    );

    typedef struct packed {
        logic [5:0]  stall;
        logic        busy;
        logic        done;
        logic        cancel;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } obs_t;

    obs_t obs, e;
    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_ID   = 6'b000111;
    localparam logic [5:0] S_EX   = 6'b001111;

    always_comb begin
        obs.stall  = stall;
        obs.busy   = mc_busy;
        obs.done   = mc_done;
        obs.cancel = mc_cancel;
        obs.flush  = o_flush;
        obs.pc     = o_new_pc;
        obs.cnt    = o_stall_cnt;
        obs.cnt4   = o_stall_cnt4;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Queue one cycle of expected outputs; the counters reflect stalls of earlier cycles.
    task automatic push_exp(input logic [5:0] s, input logic b, input logic d,
                            input logic c, input logic f, input logic [31:0] pc);
        obs_t x;
        x.stall = s; x.busy = b; x.done = d; x.cancel = c; x.flush = f; x.pc = pc;
        x.cnt  = exp_cnt;
        x.cnt4 = (exp_cnt > 15) ? 4'd15 : exp_cnt[3:0];
        exp_q.push_back(x);
        if (s[0]) exp_cnt++;
    endtask

    task automatic drive(input logic id, input logic st, input logic [5:0] n,
                         input logic fl, input logic [31:0] pc);
        id_stallreq = id; ex_mc_start = st; ex_mc_cycles = n; flush_req = fl; exc_pc = pc;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        exp_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1'($urandom), 1'($urandom), 6'($urandom), 1'($urandom), $urandom);
            push_exp(S_NONE, 0, 0, 0, 0, 0);
            @(negedge clk);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++; $display("FAIL reset_hold[%0d]: got %h want %h", k, obs, e);
            end
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            push_exp(S_NONE, 0, 0, 0, 0, 0);
            @(negedge clk);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++; $display("FAIL reset_idle[%0d]: got %h want %h", k, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        for (int k = 0; k < 3; k++) begin
            drive(k == 0, 0, 0, 0, 0);
            push_exp((k == 0) ? S_ID : S_NONE, 0, 0, 0, 0, 0);
            @(negedge clk);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++; $display("FAIL load_use[%0d]: got %h want %h", k, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    // Start cycle + n BUSY cycles stalled, one DONE cycle, one idle cycle.
    task automatic test_multicycle(input int n, input logic with_id);
        for (int k = 0; k <= n + 2; k++) begin
            if (n == 0) begin
                drive(0, k <= n + 1, 6'(n), 0, 0);
                push_exp(S_NONE, 0, 0, 0, 0, 0);
            end else if (k <= n) begin
                drive(with_id, 1, 6'(n), 0, 0);
                push_exp(S_EX, k >= 1, 0, 0, 0, 0);
            end else begin
                drive(0, 0, 0, 0, 0);
                push_exp(S_NONE, 0, k == n + 1, 0, 0, 0);
            end
            @(negedge clk);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++; $display("FAIL mc_n%0d_id%0d[%0d]: got %h want %h", n, with_id, k, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    // Flush in BUSY cycle `at` of an n-cycle op; expect cancel and no mc_done.
    task automatic test_flush_mc(input int n, input int at, input logic [31:0] pc);
        for (int k = 0; k <= at + 4; k++) begin
            if (k < at) begin
                drive(0, 1, 6'(n), 0, 0);
                push_exp(S_EX, k >= 1, 0, 0, 0, 0);
            end else if (k == at) begin
                drive(0, 0, 0, 1, pc);
                push_exp(S_NONE, 1, 0, 0, 0, 0);
            end else begin
                drive(0, 0, 0, 0, 32'hDEAD_BEEF);
                push_exp(S_NONE, 0, 0, k == at + 1, k == at + 1, (k == at + 1) ? pc : 0);
            end
            @(negedge clk);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++; $display("FAIL flush_mc_n%0d[%0d]: got %h want %h", n, k, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        pcs[0] = 32'hBFC0_0380; pcs[1] = 32'h8000_0180; pcs[2] = 32'h1234_5678;
        for (int k = 0; k < 5; k++) begin
            drive(k == 1, 0, 0, k < 2, pcs[(k < 2) ? k : 2]);
            push_exp(S_NONE, 0, 0, 0, k == 1 || k == 2, (k == 1 || k == 2) ? pcs[k - 1] : 0);
            @(negedge clk);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++; $display("FAIL back_to_back[%0d]: got %h want %h", k, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1, 1, 6'd32, 0, 0);
            push_exp(S_EX, k >= 1, 0, 0, 0, 0);
            @(negedge clk);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++; $display("FAIL pre_reset[%0d]: got %h want %h", k, obs, e);
            end
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        exp_cnt = 0;
        push_exp(S_NONE, 0, 0, 0, 0, 0);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (obs !== e) begin
            n_err++; $display("FAIL async_reset: got %h want %h", obs, e);
        end
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_exp(S_NONE, 0, 0, 0, 0, 0);
            @(negedge clk);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++; $display("FAIL post_reset[%0d]: got %h want %h", k, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 24; k++) begin
            drive(k < 20, 0, 0, 0, 0);
            push_exp((k < 20) ? S_ID : S_NONE, 0, 0, 0, 0, 0);
            @(negedge clk);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++; $display("FAIL saturation[%0d]: got %h want %h", k, obs, e);
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (o_stall_cnt4 !== 4'd15 || o_stall_cnt !== 32'd20) begin
            n_err++;
            $display("FAIL sat_final: got cnt4=%0d cnt=%0d want cnt4=15 cnt=20",
                     o_stall_cnt4, o_stall_cnt);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_multicycle(32, 0);
        test_multicycle(32, 1);
        test_multicycle(0, 0);
        test_multicycle(1, 0);
        test_flush_mc(32, 10, 32'hBFC0_0380);
        test_flush_mc(2, 2, 32'h8000_0180);
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
